if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the RV32I pipeline. It owns the PC, issues reads to the instruction SRAM, which has one cycle of read latency, and pairs each returned word with its PC. Its outputs drive the IF/ID pipeline register directly. It absorbs downstream stalls with a one-entry hold buffer and kills wrong-path fetches on a redirect.

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- NOP_INST, default 32'h0000_0013: instruction presented whenever the output is invalid.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  downstream cannot accept this cycle; the current output must be held.
- redirect_i  in  1  taken branch/jump from EX; flush and refetch.
- redirect_pc_i  in  32  redirect target; bits [1:0] are ignored and treated as 2'b00.
- im_cs_o  out  1  SRAM read enable; the SRAM samples the address on this rising edge.
- im_addr_o  out  32  SRAM byte address, word aligned.
- im_rdata_i  in  32  SRAM read data, valid one cycle after the request edge.
- if_valid_o  out  1  if_pc_o/if_inst_o carry a real instruction.
- if_pc_o  out  32  PC of the presented instruction.
- if_inst_o  out  32  presented instruction.

## Operation
- State: pc_q (next fetch address), rsp_pend_q (read issued last edge, data is on im_rdata_i now), rsp_pc_q, hold_inst_q, hold_pc_q.
- FSM with two states:
  - RUN: output comes from the SRAM response.
  - HOLD: output comes from the hold buffer.
- Address select: im_addr_o = redirect_i ? {redirect_pc_i[31:2],2'b00} : pc_q.
- Issue rule: im_cs_o = !rst_i && (redirect_i || !stall_i).
  - On issue: pc_q <= im_addr_o + 4 (mod 2^32), rsp_pc_q <= im_addr_o, rsp_pend_q <= 1.
  - Otherwise: pc_q holds.
- Output validity:
  - RUN: if_valid_o = rsp_pend_q && !redirect_i, with if_pc_o = rsp_pc_q and if_inst_o = im_rdata_i.
  - HOLD: if_valid_o = !redirect_i, with if_pc_o = hold_pc_q and if_inst_o = hold_inst_q.
  - When if_valid_o = 0: if_inst_o = NOP_INST and if_pc_o = 0.
- Transitions:
  - RUN → HOLD when stall_i && rsp_pend_q && !redirect_i. Capture hold_inst_q <= im_rdata_i and hold_pc_q <= rsp_pc_q; rsp_pend_q <= 0.
  - RUN with stall_i && !rsp_pend_q: stay in RUN, rsp_pend_q <= 0, no output.
  - HOLD with stall_i: stay in HOLD; the buffer is unchanged.
  - HOLD with !stall_i: the held instruction is consumed this cycle, the next fetch is issued at pc_q, and the FSM moves to RUN.
  - Any state with redirect_i: move to RUN. The hold buffer is discarded, the output is invalid this cycle, and the target fetch is issued.
- Priority: rst_i > redirect_i > stall_i.
- The downstream register latches only when !stall_i. Each fetched PC is presented valid, and consumed, exactly once unless flushed.

## Timing
- Reset values:
  - pc_q = RESET_PC, state = RUN, rsp_pend_q = 0.
  - hold_* = 0.
  - Outputs: if_valid_o = 0, if_pc_o = 0, if_inst_o = NOP_INST.
  - im_cs_o = 0 while rst_i is high; im_addr_o = RESET_PC.
- First cycle after reset: fetch RESET_PC (im_cs_o = 1). if_valid_o rises on the following cycle.
- Latency: 1 cycle from request edge to valid output.
- Throughput: 1 instruction/cycle with no stall.
- Redirect latency: target issued in the redirect cycle, valid on the next cycle. The redirect cycle itself is a bubble.
- Stall release from HOLD: no bubble. The held instruction in the release cycle is followed by the new response next cycle.
- Stall during the first post-reset cycle: nothing is issued and nothing is presented; pc_q stays at RESET_PC.
- Redirect during reset: ignored.
- Reset asserted mid-HOLD: the buffer is cleared; the next fetch after reset is RESET_PC.
- pc_q = 32'hFFFF_FFFC: the next fetch wraps to 32'h0000_0000.

## Test plan
- Reset release, no stall, SRAM word = addr ^ 32'hA5A5_A5A5:
  - fetches 0, 4, 8, ...; if_valid_o first high one cycle after the first im_cs_o;
  - if_pc_o/if_inst_o pairs match; one instruction per cycle.
- Stall for 3 cycles while PC 8 is presented:
  - output is held at pc = 8 for 4 cycles; im_cs_o = 0 for 3 cycles;
  - after release, 12 is presented with no bubble and no duplicate.
- Redirect to 32'h0000_0103 while PC 4 is presented:
  - if_valid_o = 0 that cycle; im_addr_o = 32'h0000_0100;
  - next cycle is pc = 0x100, then 0x104.
- Redirect and stall asserted together while in HOLD:
  - the hold buffer is dropped, the target is fetched, and the stalled instruction never reappears.
- RESET_PC = 32'hFFFF_FFF8, free run:
  - sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst_i mid-HOLD for one cycle:
  - outputs return to reset values; the first post-reset fetch is RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency SRAM and
// presents {pc, inst} to the IF/ID register with a one-entry stall buffer.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   stall_i               downstream holds the current output
//   redirect_i/_pc_i      flush and refetch from the target (bits [1:0] dropped)
//   im_cs_o/im_addr_o     SRAM read request (address sampled on the rising edge)
//   im_rdata_i            SRAM data, one cycle after the request
//   if_valid_o/_pc_o/_inst_o  presented instruction (NOP_INST/0 when invalid)
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        im_cs_o,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic        rsp_pend_q;
    logic [31:0] rsp_pc_q;
    logic [31:0] hold_inst_q;
    logic [31:0] hold_pc_q;
    logic        capture;

    always_comb begin
        im_addr_o = pc_q;
        if (rst_i) begin
            im_addr_o = RESET_PC;
        end else if (redirect_i) begin
            im_addr_o = {redirect_pc_i[31:2], 2'b00};
        end
        im_cs_o = !rst_i && (redirect_i || !stall_i);
    end

    always_comb begin
        if_valid_o = 1'b0;
        if_pc_o    = 32'h0;
        if_inst_o  = NOP_INST;
        capture    = 1'b0;
        state_d    = state_q;
        unique case (state_q)
            RUN: begin
                if (!rst_i && rsp_pend_q && !redirect_i) begin
                    if_valid_o = 1'b1;
                    if_pc_o    = rsp_pc_q;
                    if_inst_o  = im_rdata_i;
                end
                // The SRAM word is only on the bus this cycle; park it.
                if (stall_i && rsp_pend_q && !redirect_i) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!rst_i && !redirect_i) begin
                    if_valid_o = 1'b1;
                    if_pc_o    = hold_pc_q;
                    if_inst_o  = hold_inst_q;
                end
                if (!stall_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (redirect_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            rsp_pend_q  <= 1'b0;
            rsp_pc_q    <= 32'h0;
            hold_inst_q <= 32'h0;
            hold_pc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (im_cs_o) begin
                pc_q       <= im_addr_o + 32'd4;
                rsp_pc_q   <= im_addr_o;
                rsp_pend_q <= 1'b1;
            end else begin
                rsp_pend_q <= 1'b0;
            end
            if (capture) begin
                hold_inst_q <= im_rdata_i;
                hold_pc_q   <= rsp_pc_q;
            end
        end
    end

endmodule
